// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - request/result bundle between EX control and the mul/div unit
//
// Purpose: groups the pipeline-facing signals of ex_muldiv_unit.
// Ports (master = EX control / pipeline side, slave = ex_muldiv_unit):
//   start, op[1:0], operand_a[31:0], operand_b[31:0]  request (MULT/MULTU/DIV/DIVU)
//   flush                                             abort in-flight operation
//   hi_we, lo_we, wdata[31:0]                         MTHI/MTLO writes
//   busy, done, hi[31:0], lo[31:0]                    status and HI/LO registers
interface ex_muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative 32-bit multiply/divide unit owning HI/LO
//
// Purpose: executes MULT/MULTU/DIV/DIVU in a fixed 33-cycle busy window
// (32 iterations + 1 fix-up cycle) and holds the architectural HI/LO.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      ex_muldiv_unit_if.slave: start/op/operand_a/operand_b request,
//            flush, hi_we/lo_we/wdata, busy/done/hi/lo outputs
module ex_muldiv_unit (
  input  logic              clk,
  input  logic              reset_n,
  ex_muldiv_unit_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [5:0]  count;
  logic        is_div;
  logic        sign_a;
  logic        sign_b;
  logic        b_zero;
  logic [31:0] a_raw;
  // Multiply: multiplicand. Divide: divisor.
  logic [31:0] mcand;
  // Multiply: {accumulator, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient shifting in}.
  logic [63:0] prod;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Request decode: op[0]=1 selects the unsigned variant.
  logic        req_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign req_signed = ~bus.op[0];
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign a_mag = (req_signed && bus.operand_a[31]) ? 32'd0 - bus.operand_a : bus.operand_a;
  assign b_mag = (req_signed && bus.operand_b[31]) ? 32'd0 - bus.operand_b : bus.operand_b;

  // Shift-add step: the carry out of the add becomes the new top bit after the shift.
  logic [32:0] add_sum;
  logic [63:0] mult_next;

  assign add_sum   = {1'b0, prod[63:32]} + {1'b0, mcand};
  assign mult_next = prod[0] ? {add_sum, prod[31:1]} : {1'b0, prod[63:1]};

  // Restoring step on a 33-bit shifted remainder. When it fits, the true
  // difference is below the divisor, so a 32-bit subtract is exact.
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] div_next;

  assign rem_shift = {prod[63:32], prod[31]};
  assign rem_ge    = rem_shift >= {1'b0, mcand};
  assign rem_sub   = rem_shift[31:0] - mcand;
  assign div_next  = {(rem_ge ? rem_sub : rem_shift[31:0]), prod[30:0], rem_ge};

  // Sign correction and result selection for the FIX cycle.
  logic [63:0] prod_neg;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign prod_neg = 64'd0 - prod;

  always_comb begin
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (!is_div) begin
      if (sign_a ^ sign_b) begin
        fix_hi = prod_neg[63:32];
        fix_lo = prod_neg[31:0];
      end
    end else if (b_zero) begin
      fix_hi = a_raw;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_lo = (sign_a ^ sign_b) ? 32'd0 - prod[31:0] : prod[31:0];
      fix_hi = sign_a ? 32'd0 - prod[63:32] : prod[63:32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      count  <= 6'd0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= 32'd0;
      mcand  <= 32'd0;
      prod   <= 64'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            is_div <= bus.op[1];
            sign_a <= req_signed & bus.operand_a[31];
            sign_b <= req_signed & bus.operand_b[31];
            b_zero <= (bus.operand_b == 32'd0);
            a_raw  <= bus.operand_a;
            // Multiply iterates over |b| against |a|; divide shifts |a| through |b|.
            mcand  <= bus.op[1] ? b_mag : a_mag;
            prod   <= {32'd0, (bus.op[1] ? a_mag : b_mag)};
            count  <= 6'd0;
            busy_q <= 1'b1;
            state  <= S_CALC;
          end else if (!bus.start) begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            prod  <= is_div ? div_next : mult_next;
            count <= count + 6'd1;
            if (count == 6'd31) state <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
          if (!bus.flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
